spi_flash_id_responder: RTL and testbench

//  Flash-side responder for the SPI JEDEC RDID transaction, the stage directly downstream of the SPI master.

---
 rtl/spi_flash_pkg.sv | 17 +
 rtl/spi_edge_sync.sv | 33 +++
 rtl/spi_flash_id_responder.sv | 196 +++++++++++++++++++
 tb/tb_spi_flash_id_responder.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// Shared opcodes, FSM encoding and ID length for the SPI flash JEDEC-ID responder.
package spi_flash_pkg;

   localparam logic [7:0] OP_RDID = 8'h9F;
   localparam logic [7:0] OP_RDSR = 8'h05;   // reserved, not decoded yet

   localparam int ID_BITS = 24;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CMD    = 3'd1,
      RESP   = 3'd2,
      DONE   = 3'd3,
      IGNORE = 3'd4
   } state_t;

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchroniser for one asynchronous SPI input, followed by an edge-detect flop
// that yields single-clk rise/fall pulses aligned with the synchronised level.
module spi_edge_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_p0;
   logic              prev_p1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_p0 <= {STAGES{RST_VAL}};
         prev_p1 <= RST_VAL;
      end else begin
         sync_p0 <= {sync_p0[STAGES-2:0], din};
         prev_p1 <= sync_p0[STAGES-1];
      end
   end

   // stage boundary: synchronised level vs. one-clk-old copy
   assign level = sync_p0[STAGES-1];
   assign rise  = sync_p0[STAGES-1] & ~prev_p1;
   assign fall  = ~sync_p0[STAGES-1] & prev_p1;

endmodule

// File: rtl/spi_flash_id_responder.sv
// Serial-flash stand-in answering JEDEC RDID (9Fh) with a 24-bit ID on spi_miso.
// Optional build macro SPI_RESP_WRAP_EN: repeat the ID continuously instead of idling at 0.
module spi_flash_id_responder
   import spi_flash_pkg::*;
#(
   parameter logic [7:0] MANUF_ID    = 8'h20,
   parameter logic [7:0] MEM_TYPE    = 8'h20,
   parameter logic [7:0] MEM_CAP     = 8'h15,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       spi_clk,
   input  logic       spi_mosi,
   input  logic       spi_cs_n,
   output logic       spi_miso,
   output logic       busy,
   output logic       cmd_valid,
   output logic [7:0] cmd_byte,
   output logic       id_sent,
   output logic       err_cmd
);

   localparam logic [ID_BITS-1:0] ID_WORD  = {MANUF_ID, MEM_TYPE, MEM_CAP};
   localparam logic [4:0]         LAST_BIT = 5'(ID_BITS - 1);
   localparam logic [4:0]         CNT_SAT  = 5'(ID_BITS);

   function automatic logic [4:0] sat_inc(input logic [4:0] cnt);
      return (cnt >= CNT_SAT) ? CNT_SAT : cnt + 5'd1;
   endfunction

   logic sclk_s, sclk_rise, sclk_fall;
   logic cs_s, cs_rise, cs_fall;
   logic [SYNC_STAGES-1:0] mosi_p0;
   logic mosi_s;

   spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
      .clk(clk), .reset_n(reset_n), .din(spi_clk),
      .level(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
   );

   spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
      .clk(clk), .reset_n(reset_n), .din(spi_cs_n),
      .level(cs_s), .rise(cs_rise), .fall(cs_fall)
   );

   // mosi only needs the level, delayed to line up with the spi_clk edge pulses
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) mosi_p0 <= '0;
      else          mosi_p0 <= {mosi_p0[SYNC_STAGES-2:0], spi_mosi};
   end
   assign mosi_s = mosi_p0[SYNC_STAGES-1];

   state_t             state_q, state_nxt;
   logic [4:0]         bit_cnt_q, bit_cnt_nxt;
   logic [7:0]         sh_q, sh_nxt, sh_shift;
   logic [ID_BITS-1:0] id_sr_q, id_sr_nxt;
   logic [7:0]         cmd_byte_q, cmd_byte_nxt;
   logic               miso_q, miso_nxt;
   logic               cmd_valid_q, cmd_valid_nxt;
   logic               id_sent_q, id_sent_nxt;
   logic               err_q, err_nxt;
   logic               armed_q;
   logic [SYNC_STAGES:0] warm_q;

   assign sh_shift = {sh_q[6:0], mosi_s};

   // A frame may only start once the bus has been seen idle after reset, so a reset
   // in the middle of a frame does not turn the still-low cs_n into a fake start.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         sh_q        <= '0;
         id_sr_q     <= '0;
         cmd_byte_q  <= '0;
         miso_q      <= 1'b0;
         cmd_valid_q <= 1'b0;
         id_sent_q   <= 1'b0;
         err_q       <= 1'b0;
         armed_q     <= 1'b0;
         warm_q      <= '0;
      end else begin
         state_q     <= state_nxt;
         bit_cnt_q   <= bit_cnt_nxt;
         sh_q        <= sh_nxt;
         id_sr_q     <= id_sr_nxt;
         cmd_byte_q  <= cmd_byte_nxt;
         miso_q      <= miso_nxt;
         cmd_valid_q <= cmd_valid_nxt;
         id_sent_q   <= id_sent_nxt;
         err_q       <= err_nxt;
         warm_q      <= {warm_q[SYNC_STAGES-1:0], 1'b1};
         armed_q     <= armed_q | cs_rise | (warm_q[SYNC_STAGES] & cs_s & ~sclk_s);
      end
   end

   always_comb begin
      state_nxt = state_q;
      if (cs_s) begin
         state_nxt = IDLE;
      end else begin
         case (state_q)
            IDLE: if (cs_fall && armed_q) state_nxt = CMD;
            CMD: begin
               if (sclk_rise && bit_cnt_q == 5'd7)
                  state_nxt = (sh_shift == OP_RDID) ? RESP : IGNORE;
            end
            RESP: begin
`ifdef SPI_RESP_WRAP_EN
               state_nxt = RESP;
`else
               if (sclk_rise && bit_cnt_q == LAST_BIT) state_nxt = DONE;
`endif
            end
            default: state_nxt = state_q;
         endcase
      end
   end

   // In RESP bit_cnt counts rising edges already sampled by the master; the falling
   // edge right after the load must not shift, or the MSB would never be seen.
   always_comb begin
      bit_cnt_nxt   = bit_cnt_q;
      sh_nxt        = sh_q;
      id_sr_nxt     = id_sr_q;
      cmd_byte_nxt  = cmd_byte_q;
      miso_nxt      = miso_q;
      cmd_valid_nxt = 1'b0;
      id_sent_nxt   = 1'b0;
      err_nxt       = err_q;
      if (cs_s) begin
         bit_cnt_nxt = '0;
         sh_nxt      = '0;
         id_sr_nxt   = '0;
         miso_nxt    = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (cs_fall && armed_q) begin
                  bit_cnt_nxt = '0;
                  sh_nxt      = '0;
                  err_nxt     = 1'b0;
               end
            end
            CMD: begin
               if (sclk_rise) begin
                  sh_nxt      = sh_shift;
                  bit_cnt_nxt = sat_inc(bit_cnt_q);
                  if (bit_cnt_q == 5'd7) begin
                     cmd_valid_nxt = 1'b1;
                     cmd_byte_nxt  = sh_shift;
                     bit_cnt_nxt   = '0;
                     if (sh_shift == OP_RDID) begin
                        id_sr_nxt = ID_WORD;
                        miso_nxt  = ID_WORD[ID_BITS-1];
                     end else begin
                        err_nxt = 1'b1;
                     end
                  end
               end
            end
            RESP: begin
               if (sclk_rise) begin
                  if (bit_cnt_q == LAST_BIT) begin
                     id_sent_nxt = 1'b1;
`ifdef SPI_RESP_WRAP_EN
                     bit_cnt_nxt = '0;
                     id_sr_nxt   = ID_WORD;
                     miso_nxt    = ID_WORD[ID_BITS-1];
`else
                     bit_cnt_nxt = CNT_SAT;
                     id_sr_nxt   = '0;
                     miso_nxt    = 1'b0;
`endif
                  end else begin
                     bit_cnt_nxt = sat_inc(bit_cnt_q);
                  end
               end else if (sclk_fall && bit_cnt_q != 5'd0) begin
                  id_sr_nxt = {id_sr_q[ID_BITS-2:0], 1'b0};
                  miso_nxt  = id_sr_q[ID_BITS-2];
               end
            end
            default: miso_nxt = 1'b0;
         endcase
      end
   end

   assign spi_miso  = miso_q;
   assign busy      = (state_q != IDLE);
   assign cmd_valid = cmd_valid_q;
   assign cmd_byte  = cmd_byte_q;
   assign id_sent   = id_sent_q;
   assign err_cmd   = err_q;

endmodule

// File: tb/tb_spi_flash_id_responder.sv
// Randomised SPI-master bench for spi_flash_id_responder with a frame-level reference model.
module tb_spi_flash_id_responder;

   localparam logic [23:0] ID = 24'h202015;
   localparam int SYNC = 2;
`ifdef SPI_RESP_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset_n;
   logic       spi_clk, spi_mosi, spi_cs_n;
   logic       spi_miso, busy, cmd_valid, id_sent, err_cmd;
   logic [7:0] cmd_byte;

   int n_cmp = 0;
   int n_bad = 0;
   int cv_cnt = 0;
   int is_cnt = 0;

   spi_flash_id_responder dut (
      .clk(clk), .reset_n(reset_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
      .spi_cs_n(spi_cs_n), .spi_miso(spi_miso), .busy(busy), .cmd_valid(cmd_valid),
      .cmd_byte(cmd_byte), .id_sent(id_sent), .err_cmd(err_cmd)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (cmd_valid) cv_cnt++;
      if (id_sent)   is_cnt++;
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Bits the master should see on the response clocks, straight from the ID rules.
   function automatic logic [47:0] exp_resp(input logic [7:0] op, input int nbits, input int reset_at);
      logic [47:0] e;
      logic b;
      e = '0;
      for (int i = 0; i < nbits; i++) begin
         b = 1'b0;
         if (op == 8'h9F && !(reset_at >= 0 && i >= reset_at))
            if (WRAP || i < 24) b = ID[23 - (i % 24)];
         e[47 - i] = b;
      end
      return e;
   endfunction

   function automatic int exp_ids(input logic [7:0] op, input int nbits, input int reset_at);
      int eff;
      eff = (reset_at >= 0) ? reset_at : nbits;
      if (op != 8'h9F) return 0;
      if (WRAP) return eff / 24;
      return (eff >= 24) ? 1 : 0;
   endfunction

   task automatic frame(input logic [7:0] op, input int nbits, input int hp, input int reset_at);
      logic [47:0] got;
      int cv0, is0;
      bit rst_hit;
      got = '0;
      rst_hit = (reset_at >= 0);
      cv0 = cv_cnt;
      is0 = is_cnt;
      spi_cs_n = 1'b0;
      repeat (hp) @(negedge clk);
      chk("err_clr_on_cs", 48'(err_cmd), 48'(0));
      for (int i = 0; i < 8; i++) begin
         spi_mosi = op[7 - i];
         repeat (hp) @(negedge clk);
         spi_clk = 1'b1;
         repeat (hp) @(negedge clk);
         spi_clk = 1'b0;
      end
      for (int i = 0; i < nbits; i++) begin
         spi_mosi = 1'($urandom);
         repeat (hp) @(negedge clk);
         if (i == reset_at) begin
            reset_n = 1'b0;
            #1;
            chk("rst_miso", 48'(spi_miso), 48'(0));
            chk("rst_busy", 48'(busy), 48'(0));
            repeat (2) @(negedge clk);
            reset_n = 1'b1;
         end
         if (i == 0 && reset_at != 0) chk("busy_mid", 48'(busy), 48'(1));
         got[47 - i] = spi_miso;
         spi_clk = 1'b1;
         repeat (hp) @(negedge clk);
         spi_clk = 1'b0;
      end
      repeat (hp) @(negedge clk);
      spi_cs_n = 1'b1;
      repeat (SYNC + 3) @(negedge clk);
      chk("busy_end", 48'(busy), 48'(0));
      chk("miso_end", 48'(spi_miso), 48'(0));
      chk("resp_bits", got, exp_resp(op, nbits, reset_at));
      chk("cmd_valid_cnt", 48'(cv_cnt - cv0), 48'(1));
      chk("cmd_byte", 48'(cmd_byte), rst_hit ? 48'(0) : 48'(op));
      chk("err_cmd", 48'(err_cmd), 48'((!rst_hit && op != 8'h9F) ? 1 : 0));
      chk("id_sent_cnt", 48'(is_cnt - is0), 48'(exp_ids(op, nbits, reset_at)));
      repeat (hp + $urandom_range(0, 4)) @(negedge clk);
   endtask

   initial begin
      logic [7:0] op;
      int nb, hp, ra;
      reset_n  = 1'b0;
      spi_clk  = 1'b0;
      spi_mosi = 1'b0;
      spi_cs_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("rst_miso0", 48'(spi_miso), 48'(0));
      chk("rst_busy0", 48'(busy), 48'(0));
      chk("rst_cmd_valid", 48'(cmd_valid), 48'(0));
      chk("rst_cmd_byte", 48'(cmd_byte), 48'(0));
      chk("rst_id_sent", 48'(id_sent), 48'(0));
      chk("rst_err_cmd", 48'(err_cmd), 48'(0));
      reset_n = 1'b1;
      repeat (8) @(negedge clk);

      frame(8'h9F, 24, 4, -1);   // plain RDID
      frame(8'h03, 24, 4, -1);   // bad opcode
      frame(8'h9F, 12, 5, -1);   // aborted read
      frame(8'h9F, 24, 4, -1);
      frame(8'h9F, 24, 4, 5);    // reset mid response
      frame(8'h9F, 24, 6, -1);
      frame(8'h9F, 48, 4, -1);   // overrun past the ID

      for (int k = 0; k < 14; k++) begin
         op = ($urandom_range(0, 1) == 1) ? 8'h9F : 8'($urandom);
         nb = $urandom_range(0, 48);
         hp = $urandom_range(4, 7);
         ra = -1;
         if (nb > 0 && $urandom_range(0, 4) == 0) ra = $urandom_range(0, nb - 1);
         frame(op, nb, hp, ra);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
